// File: rtl/exc_sequencer.sv
// exc_sequencer: MIPS-style exception/ERET commit sequencer driving CP0 writes and pipeline redirect.
// Define CP0_INT_SYNC_EN to pass hw_int through a two-flop synchronizer before use.
module exc_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid,
  input  logic [6:0]  exc_flags,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_badaddr,
  input  logic        exc_in_ds,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_cause,
  input  logic [31:0] cp0_epc,
  output logic [31:0] cp0_we,
  output logic [31:0] cp0_epc_o,
  output logic [31:0] cp0_badvaddr_o,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic        cp0_exl,
  output logic        stall,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);
  typedef enum logic [2:0] {IDLE, EXC_COMMIT, ERET_COMMIT, REDIRECT, DRAIN} state_t;
  state_t      state_q, state_d;
  logic [31:0] we_q, we_d, epc_o_q, epc_o_d, badv_q, badv_d, rpc_q, rpc_d;
  logic [4:0]  code_q, code_d, code;
  logic        bd_q, bd_d, exl_q, exl_d, stall_q, stall_d, flush_q, flush_d, rv_q, rv_d;
  logic [5:0]  hw_int_eff;
  logic        int_pend, take_exc, take_eret, addr_err;
  logic        unused_bits;
`ifdef CP0_INT_SYNC_EN
  logic [5:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= hw_int;
      sync2_q <= sync1_q;
    end
  assign hw_int_eff = sync2_q;
`else
  assign hw_int_eff = hw_int;
`endif
  assign unused_bits = ^{cp0_status[31:16], cp0_status[7:2], cp0_cause[31:10], cp0_cause[7:0]};
  assign int_pend  = cp0_status[0] & ~cp0_status[1] & |(cp0_status[15:8] & {hw_int_eff, cp0_cause[9:8]});
  assign take_exc  = exc_valid & (|exc_flags | int_pend);
  assign take_eret = exc_valid & eret & ~take_exc;
  assign code = int_pend     ? 5'h00 :
                exc_flags[0] ? 5'h04 :
                exc_flags[1] ? 5'h0A :
                exc_flags[2] ? 5'h0C :
                exc_flags[3] ? 5'h08 :
                exc_flags[4] ? 5'h09 :
                exc_flags[5] ? 5'h04 : 5'h05;
  // Address errors only count when they are the winning cause.
  assign addr_err = ~int_pend & (exc_flags[0] | (~|exc_flags[4:1] & |exc_flags[6:5]));
  always_comb begin
    state_d = state_q;
    we_d    = '0;
    epc_o_d = '0;
    badv_d  = '0;
    rpc_d   = '0;
    code_d  = '0;
    bd_d    = 1'b0;
    exl_d   = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    rv_d    = 1'b0;
    case (state_q)
      IDLE:
        if (take_exc) begin
          state_d    = EXC_COMMIT;
          we_d[13]   = 1'b1;
          we_d[12]   = 1'b1;
          we_d[14]   = ~cp0_status[1];
          we_d[8]    = addr_err;
          epc_o_d    = exc_in_ds ? exc_pc - 32'd4 : exc_pc;
          badv_d     = addr_err ? (exc_flags[0] ? exc_pc : exc_badaddr) : '0;
          code_d     = code;
          bd_d       = exc_in_ds & ~cp0_status[1];
          exl_d      = 1'b1;
          stall_d    = 1'b1;
        end else if (take_eret) begin
          state_d    = ERET_COMMIT;
          we_d[12]   = 1'b1;
          stall_d    = 1'b1;
        end
      EXC_COMMIT, ERET_COMMIT: begin
        state_d = REDIRECT;
        rpc_d   = state_q == EXC_COMMIT ? 32'hBFC0_0380 : cp0_epc;
        flush_d = 1'b1;
        rv_d    = 1'b1;
        stall_d = 1'b1;
      end
      REDIRECT: state_d = DRAIN;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      we_q    <= '0;
      epc_o_q <= '0;
      badv_q  <= '0;
      rpc_q   <= '0;
      code_q  <= '0;
      bd_q    <= 1'b0;
      exl_q   <= 1'b0;
      stall_q <= 1'b0;
      flush_q <= 1'b0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      epc_o_q <= epc_o_d;
      badv_q  <= badv_d;
      rpc_q   <= rpc_d;
      code_q  <= code_d;
      bd_q    <= bd_d;
      exl_q   <= exl_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
      rv_q    <= rv_d;
    end
  assign cp0_we         = we_q;
  assign cp0_epc_o      = epc_o_q;
  assign cp0_badvaddr_o = badv_q;
  assign cp0_exccode    = code_q;
  assign cp0_bd         = bd_q;
  assign cp0_exl        = exl_q;
  assign stall          = stall_q;
  assign flush          = flush_q;
  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
endmodule

// File: doc/exc_sequencer.md
EXC_SEQUENCER -- requirements
Module: exc_sequencer

Interface
REQ-001 The block SHALL have ports `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port `rst`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 The block SHALL have port `exc_valid`, input, 1 bit: the MEM-stage instruction is valid.
REQ-004 The block SHALL have port `exc_flags`, input, 7 bits: [0] fetch AdEL, [1] RI, [2] Ov, [3] Syscall, [4] Break, [5] data AdEL, [6] AdES.
REQ-005 The block SHALL have ports `exc_pc` (input, 32: faulting PC), `exc_badaddr` (input, 32: faulting data address) and `exc_in_ds` (input, 1: instruction is in a delay slot).
REQ-006 The block SHALL have port `eret`, input, 1 bit: the MEM-stage instruction is ERET.
REQ-007 The block SHALL have ports `hw_int` (input, 6), `cp0_status` (input, 32), `cp0_cause` (input, 32) and `cp0_epc` (input, 32): current CP0 register values.
REQ-008 The block SHALL have port `cp0_we`, output, 32 bits: per-register CP0 write strobe, bit n selects register n.
REQ-009 The block SHALL have outputs `cp0_epc_o` (32), `cp0_badvaddr_o` (32), `cp0_exccode` (5), `cp0_bd` (1) and `cp0_exl` (1): data for the CP0 write.
REQ-010 The block SHALL have outputs `stall` (1), `flush` (1), `redirect_valid` (1) and `redirect_pc` (32): pipeline control.

Function
REQ-011 Interrupt pending SHALL be `Status[0] & ~Status[1] & |(Status[15:8] & {hw_int_eff, Cause[9:8]})`.
- `hw_int_eff` is defined by REQ-025/026.
REQ-012 Exception priority SHALL be, highest first:
- interrupt (ExcCode 0x00)
- fetch AdEL (0x04)
- RI (0x0A)
- Ov (0x0C)
- Syscall (0x08)
- Break (0x09)
- data AdEL (0x04)
- AdES (0x05)
REQ-013 The FSM SHALL have five states: IDLE, EXC_COMMIT, ERET_COMMIT, REDIRECT and DRAIN.
REQ-014 In IDLE, when `exc_valid` is high and (any flag is set or an interrupt is pending), the block SHALL latch PC, BadAddr, BD and ExcCode, go to EXC_COMMIT and assert `stall`.
REQ-015 In IDLE, when `exc_valid` and `eret` are high with no exception and no interrupt, the block SHALL go to ERET_COMMIT.
- An exception always wins over ERET.
REQ-016 In EXC_COMMIT (one cycle), the block SHALL:
- pulse `cp0_we[13]` and `cp0_we[12]` with `cp0_exl` = 1;
- pulse `cp0_we[14]` with `cp0_epc_o` = BD ? pc-4 : pc (modulo 2^32) and `cp0_bd` = BD, only if Status[1] was 0 at latch;
- pulse `cp0_we[8]` with `cp0_badvaddr_o` only for AdEL/AdES, where fetch AdEL uses pc and data AdEL/AdES uses `exc_badaddr`.
REQ-017 In ERET_COMMIT (one cycle), the block SHALL pulse `cp0_we[12]` with `cp0_exl` = 0 and latch `cp0_epc` as the redirect target.
REQ-018 In REDIRECT (one cycle), the block SHALL assert `flush` and `redirect_valid`.
- `redirect_pc` = 0xBFC00380 after an exception, or the latched EPC after ERET.
REQ-019 In DRAIN (one cycle), `stall` SHALL be deasserted, and the block SHALL return to IDLE while ignoring inputs, so a flushed instruction cannot retrigger.
REQ-020 `stall` SHALL be high in EXC_COMMIT, ERET_COMMIT and REDIRECT.
- Exception-entry latency: detect cycle N, CP0 write N+1, redirect N+2, IDLE at N+4.
REQ-021 Outside IDLE, `exc_valid`, `eret` and interrupts SHALL be ignored.
- Interrupts remain pending and are sampled again in IDLE.
REQ-022 All CP0 strobes SHALL be single-cycle pulses.
- `cp0_we` bits other than 8, 12, 13 and 14 SHALL never assert.

Reset
REQ-023 While `rst` = 0, the FSM SHALL be IDLE and all outputs 0, including `redirect_pc` = 0 and `cp0_we` = 0.
REQ-024 Reset asserted mid-sequence SHALL abort immediately: no further strobes, `flush` or redirect.
- After release, the block SHALL start in IDLE.

Configuration
REQ-025 With `CP0_INT_SYNC_EN` defined, `hw_int` SHALL pass a two-flop synchronizer (reset to 0) before use, adding 2 cycles of interrupt latency.
REQ-026 Without `CP0_INT_SYNC_EN`, `hw_int` SHALL be used directly as `hw_int_eff`.

Verification
REQ-027 RI scenario: `exc_valid` = 1, `exc_flags` = 0x02, pc = 0x80001000, not in a delay slot, Status = 0x0040FF01 -> next cycle:
- `cp0_we[14,13,12]` = 1, `cp0_we[8]` = 0;
- `cp0_epc_o` = 0x80001000, ExcCode = 0x0A;
- following cycle `flush` = 1 and `redirect_pc` = 0xBFC00380.
REQ-028 Data AdES with flags 0x40, pc = 0x80002004, in a delay slot, badaddr = 0x00000003 -> `cp0_epc_o` = 0x80002000, `cp0_bd` = 1, `cp0_badvaddr_o` = 0x00000003, ExcCode = 0x05.
REQ-029 Interrupt precedence: `hw_int` = 0x01 with Status IM2 and IE set, EXL = 0, and `exc_flags` = 0x08 in the same cycle -> ExcCode = 0x00.
- With `CP0_INT_SYNC_EN`, detection occurs 2 cycles after `hw_int` rises.
REQ-030 ERET: `eret` = 1, `cp0_epc` = 0x80003000 -> `cp0_we[12]` = 1 with `cp0_exl` = 0, then `redirect_pc` = 0x80003000.
- ERET with `exc_flags` = 0x04 -> exception path, ExcCode = 0x0C.
REQ-031 Status.EXL = 1 plus Syscall -> `cp0_we[14]` = 0, `cp0_we[13]` = 1.
- `rst` pulled low during EXC_COMMIT -> `flush` never asserts and all outputs are 0.
